// File: rtl/goldschmidt_iter.sv
// Purpose : Goldschmidt divider controller, Q = N/D in Q1.18, driving one shared
//           external multiply-and-round-to-nearest-even unit over a req/ack handshake.
// Latency : 2+2*ITER multiplies plus one DONE cycle. With zero-wait acks and
//           ITER=3, done rises 9 cycles after the start-accept edge.
// Backpr. : mul_req is held with stable operands until mul_ack. The ack is
//           consumed in the cycle it is seen. start is ignored while busy.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, n_in, d_in,  begin a division (sampled in IDLE only); dividend,
//   k0_in               divisor normalised to [1.0,2.0), reciprocal seed ~1/d_in
//   mul_req/mul_a/mul_b request to the shared multiplier with its operands
//   mul_ack/mul_r       multiplier completion and RNE-rounded Q1.18 product
//   busy, done          operation in flight; one-cycle completion pulse
//   q_out, dz           quotient (held until the next done), divide-by-zero flag
//   iter_cnt            refinement iteration index, for debug
//
// Build option: define GS_EARLY_EXIT_EN to finish as soon as the refined
// divisor becomes exactly 1.0. When it is undefined, ITER iterations always run.

module goldschmidt_iter #(
  parameter int ITER = 3,
  parameter int W    = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] n_in,
  input  logic [W-1:0] d_in,
  input  logic [W-1:0] k0_in,
  output logic         mul_req,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic         mul_ack,
  input  logic [W-1:0] mul_r,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q_out,
  output logic         dz,
  output logic [2:0]   iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_N0,
    S_MUL_D0,
    S_MUL_N,
    S_MUL_D,
    S_DONE
  } state_t;

  // 1.0 in Q1.(W-1), and the saturated quotient reported on divide-by-zero.
  localparam logic [W-1:0] ONE  = W'(1) << (W-1);
  localparam logic [W-1:0] QSAT = '1;
  localparam logic [2:0]   ITER_L = 3'(ITER);

`ifdef GS_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  state_t state, state_nxt;

  logic [W-1:0] nr;     // running numerator
  logic [W-1:0] dr;     // running denominator, converges to 1.0
  logic [W-1:0] kr;     // reciprocal seed
  logic [W-1:0] f_q;    // correction factor 2.0-D for the current iteration

  logic [2:0]   cnt_inc;
  logic         d_unity;
  logic [W-1:0] f_new;

  assign cnt_inc = iter_cnt + 3'd1;

  // Early exit is judged on the product being written back into Dr.
  assign d_unity = EarlyExit && (mul_r == ONE);

  // 2.0 - D modulo 2^W. It is taken from the denominator product as it is
  // written back, so both multiplies of the next iteration use the same
  // factor even though Dr itself changes at the end of MUL_D.
  assign f_new = '0 - mul_r;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs. Operands come straight from the
  // registers, so they cannot move until the ack edge updates them.
  always_comb begin
    state_nxt = state;
    mul_req   = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    done      = 1'b0;
    busy      = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (d_in == '0) ? S_DONE : S_MUL_N0;
        end
      end

      S_MUL_N0: begin
        mul_req = 1'b1;
        mul_a   = nr;
        mul_b   = kr;
        if (mul_ack) begin
          state_nxt = S_MUL_D0;
        end
      end

      S_MUL_D0: begin
        mul_req = 1'b1;
        mul_a   = dr;
        mul_b   = kr;
        if (mul_ack) begin
          state_nxt = d_unity ? S_DONE : S_MUL_N;
        end
      end

      S_MUL_N: begin
        mul_req = 1'b1;
        mul_a   = nr;
        mul_b   = f_q;
        if (mul_ack) begin
          state_nxt = S_MUL_D;
        end
      end

      S_MUL_D: begin
        mul_req = 1'b1;
        mul_a   = dr;
        mul_b   = f_q;
        if (mul_ack) begin
          state_nxt = ((cnt_inc == ITER_L) || d_unity) ? S_DONE : S_MUL_N;
        end
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath registers. q_out/dz are loaded on the edge that enters DONE so
  // they are already valid while done is high. They then hold until the next
  // completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nr       <= '0;
      dr       <= '0;
      kr       <= '0;
      f_q      <= '0;
      iter_cnt <= '0;
      q_out    <= '0;
      dz       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            nr       <= n_in;
            dr       <= d_in;
            kr       <= k0_in;
            iter_cnt <= '0;
            if (d_in == '0) begin
              q_out <= QSAT;
              dz    <= 1'b1;
            end
          end
        end

        S_MUL_N0: begin
          if (mul_ack) begin
            nr <= mul_r;
          end
        end

        S_MUL_D0: begin
          if (mul_ack) begin
            dr       <= mul_r;
            f_q      <= f_new;
            iter_cnt <= '0;
            if (state_nxt == S_DONE) begin
              q_out <= nr;
              dz    <= 1'b0;
            end
          end
        end

        S_MUL_N: begin
          if (mul_ack) begin
            nr <= mul_r;
          end
        end

        S_MUL_D: begin
          if (mul_ack) begin
            dr       <= mul_r;
            f_q      <= f_new;
            iter_cnt <= cnt_inc;
            if (state_nxt == S_DONE) begin
              q_out <= nr;
              dz    <= 1'b0;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_goldschmidt_iter.sv
// Bench for goldschmidt_iter: a responder stands in for the shared RNE multiplier
// with a programmable ack delay. Each division is compared against a
// plain-arithmetic Goldschmidt reference for the quotient, the latency and
// the multiply count.

module tb_goldschmidt_iter;

  localparam int ITER = 3;
  localparam logic [18:0] ONE = 19'h40000;
`ifdef GS_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [18:0] n_in, d_in, k0_in;
  logic        mul_req;
  logic [18:0] mul_a, mul_b;
  logic        mul_ack;
  logic [18:0] mul_r;
  logic        busy, done, dz;
  logic [18:0] q_out;
  logic [2:0]  iter_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int stall    = 0;
  int nmul     = 0;
  int req_cycles = 0;
  bit inject_ack = 0;

  goldschmidt_iter #(.ITER(ITER), .W(19)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .n_in(n_in), .d_in(d_in), .k0_in(k0_in),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ack(mul_ack), .mul_r(mul_r),
    .busy(busy), .done(done), .q_out(q_out), .dz(dz), .iter_cnt(iter_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Q1.18 x Q1.18 product rounded to nearest, ties to even, kept to 19 bits.
  function automatic logic [18:0] rne(input logic [18:0] a, input logic [18:0] b);
    logic [37:0] p;
    logic [19:0] q;
    logic [17:0] rem;
    p   = 38'(a) * 38'(b);
    q   = p[37:18];
    rem = p[17:0];
    if (rem > 18'h20000 || (rem == 18'h20000 && q[0])) q = q + 20'd1;
    return q[18:0];
  endfunction

  // Reference Goldschmidt division: seed, then ITER rounds of N*=F, D*=F.
  task automatic model_div(input logic [18:0] n, input logic [18:0] d, input logic [18:0] k,
                           output logic [18:0] q, output logic qdz, output int mults);
    logic [18:0] nn, dd, f;
    mults = 0;
    if (d == 19'd0) begin
      q = 19'h7FFFF; qdz = 1'b1;
      return;
    end
    qdz = 1'b0;
    nn = rne(n, k);
    dd = rne(d, k);
    mults = 2;
    if (!(EARLY && dd == ONE)) begin
      for (int i = 0; i < ITER; i++) begin
        f  = 19'(20'h80000 - {1'b0, dd});
        nn = rne(nn, f);
        dd = rne(dd, f);
        mults += 2;
        if (EARLY && dd == ONE) break;
      end
    end
    q = nn;
  endtask

  // Multiplier responder: acks after 'stall' extra cycles and checks that the
  // operands are held steady while it waits.
  initial begin
    logic [18:0] cap_a, cap_b;
    int wcnt;
    mul_ack = 1'b0;
    mul_r   = '0;
    wcnt    = 0;
    cap_a   = '0;
    cap_b   = '0;
    forever begin
      @(negedge clk);
      if (mul_ack) begin
        mul_ack = 1'b0;
        wcnt    = 0;
      end
      if (!mul_req) wcnt = 0;
      if (mul_req) begin
        req_cycles++;
        if (wcnt == 0) begin
          cap_a = mul_a;
          cap_b = mul_b;
        end else begin
          check("stall_a_stable", mul_a, cap_a);
          check("stall_b_stable", mul_b, cap_b);
        end
        if (wcnt == stall) begin
          mul_ack = 1'b1;
          mul_r   = rne(mul_a, mul_b);
          nmul++;
        end else begin
          wcnt++;
        end
      end else if (inject_ack) begin
        mul_ack = 1'b1;
        mul_r   = 19'h15555;
      end
    end
  end

  // One division: launches it, optionally fires an extra start mid-flight,
  // and checks result, latency, pulse count and multiplier traffic.
  task automatic run_div(input string tag, input logic [18:0] n, input logic [18:0] d,
                         input logic [18:0] k, input int st, input bit mid);
    logic [18:0] eq, gq;
    logic        edz, gdz;
    logic [2:0]  git;
    int em, lat, pulses, m0, r0;
    bit seen;
    model_div(n, d, k, eq, edz, em);
    stall = st;
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    n_in = n; d_in = d; k0_in = k; start = 1'b1;
    m0 = nmul; r0 = req_cycles;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; pulses = 0; seen = 0;
    gq = '0; gdz = 1'b0; git = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, "_busy"}, busy, 1);
      if (mid && c == 4) begin
        n_in = ~n; d_in = 19'h70000; k0_in = 19'h24924; start = 1'b1;
      end
      if (mid && c == 5) start = 1'b0;
      if (done) begin
        pulses++;
        if (!seen) begin
          seen = 1; lat = c; gq = q_out; gdz = dz; git = iter_cnt;
        end
      end
      if (seen && c >= lat + 6) break;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, lat, 1 + em * (st + 1));
    check({tag, "_q"}, gq, eq);
    check({tag, "_dz"}, gdz, edz);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_mults"}, nmul - m0, em);
    check({tag, "_req_cycles"}, req_cycles - r0, em * (st + 1));
    check({tag, "_q_hold"}, q_out, eq);
    if (!edz) check({tag, "_iter_cnt"}, git, (em - 2) / 2);
  endtask

  initial begin
    logic [18:0] rn, rd, rk;
    longint kk;
    int diff;
    rst_n = 1'b0; start = 1'b0;
    n_in = '0; d_in = '0; k0_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mul_req", mul_req, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q_out", q_out, 0);
    check("rst_dz", dz, 0);
    check("rst_iter_cnt", iter_cnt, 0);
    rst_n = 1'b1;

    run_div("identity", 19'h40000, 19'h40000, 19'h40000, 0, 0);
    run_div("div1p5", 19'h40000, 19'h60000, 19'h2AAAB, 0, 0);
    diff = int'(q_out) - int'(19'h2AAAB);
    check("div1p5_within_1lsb", (diff <= 1 && diff >= -1), 1);
    run_div("divzero", 19'h12345, 19'h00000, 19'h2AAAB, 0, 0);
    run_div("stall3", 19'h40000, 19'h60000, 19'h2AAAB, 3, 0);
    run_div("stall3_b", 19'h3A5C1, 19'h5B3D0, 19'h2CF00, 3, 0);
    run_div("busy_start", 19'h2F0F0, 19'h48000, 19'h38E39, 1, 1);

    for (int i = 0; i < 20; i++) begin
      rd = 19'(32'h40000 + $urandom_range(0, 32'h3FFFF));
      kk = (64'sd1 <<< 36) / longint'(rd) + longint'($urandom_range(0, 64)) - 64'sd32;
      rk = kk[18:0];
      rn = 19'($urandom_range(0, 32'h7FFFF));
      run_div("rand", rn, rd, rk, int'($urandom_range(0, 2)), 0);
    end

    // Reset during the first MUL_N with a request outstanding.
    stall = 2;
    @(negedge clk);
    n_in = 19'h30000; d_in = 19'h50000; k0_in = 19'h33333; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    check("midrst_req_before", mul_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_mul_req", mul_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_q_out", q_out, 0);
    check("midrst_dz", dz, 0);
    check("midrst_iter_cnt", iter_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1; inject_ack = 1'b1;
    @(posedge clk);
    #1 inject_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("late_ack_busy", busy, 0);
      check("late_ack_done", done, 0);
      check("late_ack_req", mul_req, 0);
    end
    run_div("after_rst", 19'h30000, 19'h50000, 19'h33333, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/goldschmidt_iter.md
Name: goldschmidt_iter

Overview:
- Iterative Goldschmidt divider controller for the Q1.18 datapath. Computes Q = N/D from a caller-supplied reciprocal seed K0.
- Owns no multiplier. Drives one shared 19x19 multiply-and-round-to-nearest-even unit over a req/ack handshake and consumes its 19-bit rounded result.
- Sits directly downstream of the multiply/round stage and feeds quotients to the result writeback.

Parameters:
- ITER, 3: number of refinement iterations after seeding (1..7).
- W, 19: operand/result width, Q1.(W-1) unsigned fixed point. Only 19 is verified.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  begin division; sampled only in IDLE.
- n_in  in  19  dividend, Q1.18.
- d_in  in  19  divisor, Q1.18, normalised to [1.0,2.0).
- k0_in  in  19  reciprocal seed, Q1.18, approx 1/d_in.
- mul_req  out  1  multiply request; held high until acked.
- mul_a  out  19  multiplicand; stable while mul_req=1.
- mul_b  out  19  multiplier; stable while mul_req=1.
- mul_ack  in  1  multiply complete; mul_r valid this cycle.
- mul_r  in  19  RNE-rounded product, Q1.18.
- busy  out  1  high from the cycle after start is accepted through DONE.
- done  out  1  one-cycle pulse; q_out valid.
- q_out  out  19  quotient, Q1.18; holds until the next done.
- dz  out  1  divide-by-zero flag; valid with done.
- iter_cnt  out  3  current iteration index, for debug.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; mul_req=0, mul_a=mul_b=0, busy=0, done=0, q_out=0, dz=0, iter_cnt=0.
  - Reset has priority over every other input, including mid-operation.
  - An outstanding request is abandoned. A mul_ack arriving afterwards is ignored.
- Accepting a division: in IDLE with start=1, latch n_in, d_in, k0_in into Nr, Dr, Kr.
  - If d_in==0: go to DONE with q_out=0x7FFFF, dz=1, no multiplies issued.
  - Otherwise go to MUL_N0.
- States: IDLE, MUL_N0, MUL_D0, MUL_N, MUL_D, DONE.
- MUL_N0: mul_a=Nr, mul_b=Kr. On ack, Nr<=mul_r; go to MUL_D0.
- MUL_D0: mul_a=Dr, mul_b=Kr. On ack, Dr<=mul_r, iter_cnt<=0; go to MUL_N.
- Iteration correction factor: F=(2^19-Dr) mod 2^19, i.e. 2.0-D in Q1.18. F is computed combinationally from the registered Dr and held constant across MUL_N and MUL_D.
- MUL_N: mul_a=Nr, mul_b=F. On ack, Nr<=mul_r; go to MUL_D.
- MUL_D: mul_a=Dr, mul_b=F. On ack, Dr<=mul_r and iter_cnt increments.
  - If the new iter_cnt==ITER: go to DONE.
  - Otherwise go to MUL_N.
  - F must use the pre-update Dr for both multiplies of one iteration; capture F on entry to MUL_N.
- Handshake, every MUL_* state:
  - mul_req=1 for the whole state. mul_a/mul_b do not change until the ack cycle.
  - The ack is consumed in the cycle it is seen. mul_req drops, or re-asserts with new operands, on the next cycle.
  - Zero-wait ack (ack in the same cycle req rises) is legal.
  - mul_ack while mul_req=0 is ignored.
- DONE: done=1 for exactly one cycle; q_out<=Nr (unless dz); busy=1; then IDLE.
- start while busy is ignored, not queued.
- Latency with zero-wait ack: 2+2*ITER multiply cycles plus 1 DONE cycle. With ITER=3, done is high on the 9th cycle after the start-accept edge.
- Multiply count per division: exactly 2+2*ITER.

Optional Feature:
- Macro: GS_EARLY_EXIT_EN.
- Defined: after any MUL_D ack (and after MUL_D0), if the captured Dr==0x40000 (exactly 1.0), go straight to DONE; iter_cnt shows the completed iterations.
- Undefined: always run ITER iterations, so latency depends only on ack timing.

Test Plan:
- Identity: N=0x40000, D=0x40000, K0=0x40000, zero-wait ack model -> q_out=0x40000, dz=0, done 9 cycles after start. With GS_EARLY_EXIT_EN: 8 multiplies without the macro; done after MUL_D0 (2 multiplies) with it.
- Divide by 1.5: N=0x40000, D=0x60000, K0=0x2AAAB, bench RNE model -> q_out within +/-1 LSB of 0x2AAAB, exactly 8 req/ack transactions.
- Divide by zero: D=0, N=0x12345 -> no mul_req ever, done the cycle after DONE entry, q_out=0x7FFFF, dz=1.
- Stalled multiplier: ack delayed 3 cycles on every request -> mul_a/mul_b constant during each stall, result identical to zero-wait run, done 1+8*4 cycles after accept.
- start while busy: second start mid-iteration with different operands -> ignored; first result unchanged; exactly one done pulse.
- Reset mid-op: rst_n=0 during MUL_N with mul_req=1 -> next cycle mul_req=0, busy=0, q_out=0. A late mul_ack is ignored, and a subsequent division completes correctly.
